// File: rtl/faims_pkg.sv
// Shared definitions for the FAIMS SPI register block: register map, CTRL bits,
// frame layout and deserializer state encoding.
package faims_pkg;

    localparam int FRAME_BITS = 24;
    localparam int HDR_BITS   = 8;

    localparam logic [6:0] ADDR_CTRL     = 7'h00;
    localparam logic [6:0] ADDR_PERIOD   = 7'h01;
    localparam logic [6:0] ADDR_PULSELEN = 7'h02;
    localparam logic [6:0] ADDR_WORK     = 7'h03;
    localparam logic [6:0] ADDR_STATUS   = 7'h04;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_RUN    = 1;
    localparam int CTRL_CLRERR = 2;

    localparam logic [9:0] MIN_PERIOD = 10'd4;

    typedef enum logic [1:0] {
        SPI_IDLE = 2'd0,
        SPI_ADDR = 2'd1,
        SPI_DATA = 2'd2,
        SPI_DONE = 2'd3
    } spiState_t;

    typedef struct packed {
        logic        rd;
        logic [6:0]  addr;
        logic [15:0] data;
    } spiFrame_t;

    // Pulse must occupy strictly less than half the period.
    function automatic logic pulseFits(input logic [9:0] period, input logic [9:0] pulseLen);
        return {pulseLen, 1'b0} < {1'b0, period};
    endfunction

endpackage

// File: rtl/faims_spi_shifter.sv
// SPI mode-0 bit deserializer: input synchronizers, edge detect, frame FSM and
// bit count. MISO shifting exists only when FAIMS_SPI_READBACK_EN is defined.
module faims_spi_shifter
    import faims_pkg::*;
(
    input  logic      CLK,
    input  logic      i_reset,
    input  logic      i_sclk,
    input  logic      i_cs_n,
    input  logic      i_mosi,
`ifdef FAIMS_SPI_READBACK_EN
    input  logic [15:0] rdData,
    output logic [6:0]  rdAddr,
    output logic        miso,
`endif
    output logic      frameDone,
    output spiFrame_t frame
);

    logic [1:0] sclkSync, csSync, mosiSync;
    logic       sclkPrev, csPrev;
    logic       sclkRise, csFall, csRise;
    spiState_t  state;
    logic [4:0] bitCnt;

    // CS sync resets to "asserted" so a reset released mid-frame sees no falling
    // edge and waits for the next genuine one.
    always_ff @(posedge CLK or negedge i_reset) begin
        if (!i_reset) begin
            sclkSync <= 2'b00;
            csSync   <= 2'b00;
            mosiSync <= 2'b00;
            sclkPrev <= 1'b0;
            csPrev   <= 1'b0;
        end else begin
            sclkSync <= {sclkSync[0], i_sclk};
            csSync   <= {csSync[0], i_cs_n};
            mosiSync <= {mosiSync[0], i_mosi};
            sclkPrev <= sclkSync[1];
            csPrev   <= csSync[1];
        end
    end

    assign sclkRise = sclkSync[1] & ~sclkPrev;
    assign csFall   = ~csSync[1] & csPrev;
    assign csRise   = csSync[1] & ~csPrev;

    always_ff @(posedge CLK or negedge i_reset) begin
        if (!i_reset) begin
            state     <= SPI_IDLE;
            bitCnt    <= '0;
            frame     <= '0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (csRise) begin
                state <= SPI_IDLE;
            end else if (csFall) begin
                state  <= SPI_ADDR;
                bitCnt <= '0;
            end else if (sclkRise && (state == SPI_ADDR || state == SPI_DATA)) begin
                frame  <= spiFrame_t'({frame[FRAME_BITS-2:0], mosiSync[1]});
                bitCnt <= bitCnt + 5'd1;
                if (bitCnt == 5'(HDR_BITS - 1))
                    state <= SPI_DATA;
                if (bitCnt == 5'(FRAME_BITS - 1)) begin
                    state     <= SPI_DONE;
                    frameDone <= 1'b1;
                end
            end
        end
    end

`ifdef FAIMS_SPI_READBACK_EN
    logic       sclkFall;
    logic       hdrRd;
    logic [3:0] outIdx;

    assign sclkFall = ~sclkSync[1] & sclkPrev;
    assign outIdx   = 4'(5'd23 - bitCnt);

    always_ff @(posedge CLK or negedge i_reset) begin
        if (!i_reset) begin
            hdrRd  <= 1'b0;
            rdAddr <= '0;
            miso   <= 1'b0;
        end else begin
            if (state == SPI_ADDR && sclkRise && bitCnt == 5'(HDR_BITS - 1))
                {hdrRd, rdAddr} <= {frame[6:0], mosiSync[1]};
            if (state != SPI_DATA)
                miso <= 1'b0;
            else if (sclkFall)
                miso <= hdrRd & rdData[outIdx];
        end
    end
`endif

endmodule

// File: rtl/faims_spi_regs.sv
// FAIMS SPI register block: decode, validation and strobe-aligned commit.
// Define FAIMS_SPI_READBACK_EN to enable register readback on MISO.
module faims_spi_regs
    import faims_pkg::*;
#(
    parameter int DEF_PERIOD   = 250,
    parameter int DEF_PULSELEN = 20,
    parameter int DEF_WORK     = 50
) (
    input  logic       CLK,
    input  logic       i_reset,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_miso,
    input  logic       i_periodStrobe,
    output logic       o_enable,
    output logic       o_run,
    output logic [9:0] o_parFaimsPeriod,
    output logic [9:0] o_parFaimsPulseLen,
    output logic [7:0] o_parWork,
    output logic       o_err
);

    logic       frameDone;
    spiFrame_t  frame;
    logic       wrEn, reject;
    logic [9:0] shPeriod, shPulse;
    logic [7:0] shWork, rejCnt;

`ifdef FAIMS_SPI_READBACK_EN
    logic [6:0]  rdAddr;
    logic [15:0] rdData;

    always_comb begin
        rdData = 16'h0000;
        case (rdAddr)
            ADDR_CTRL:     rdData = {14'd0, o_run, o_enable};
            ADDR_PERIOD:   rdData = {6'd0, shPeriod};
            ADDR_PULSELEN: rdData = {6'd0, shPulse};
            ADDR_WORK:     rdData = {8'd0, shWork};
            ADDR_STATUS:   rdData = {rejCnt, 7'd0, o_err};
            default:       rdData = 16'h0000;
        endcase
    end
`else
    assign o_miso = 1'b0;
`endif

    faims_spi_shifter uShifter (
        .CLK       (CLK),
        .i_reset   (i_reset),
        .i_sclk    (i_sclk),
        .i_cs_n    (i_cs_n),
        .i_mosi    (i_mosi),
`ifdef FAIMS_SPI_READBACK_EN
        .rdData    (rdData),
        .rdAddr    (rdAddr),
        .miso      (o_miso),
`endif
        .frameDone (frameDone),
        .frame     (frame)
    );

    assign wrEn = frameDone & ~frame.rd;

    // Each timing value is validated against the other's current shadow.
    always_comb begin
        reject = 1'b0;
        if (wrEn) begin
            case (frame.addr)
                ADDR_PERIOD:   reject = (frame.data[9:0] < MIN_PERIOD) || !pulseFits(frame.data[9:0], shPulse);
                ADDR_PULSELEN: reject = !pulseFits(shPeriod, frame.data[9:0]);
                default:       reject = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge i_reset) begin
        if (!i_reset) begin
            o_enable           <= 1'b0;
            o_run              <= 1'b0;
            o_err              <= 1'b0;
            rejCnt             <= '0;
            shPeriod           <= 10'(DEF_PERIOD);
            shPulse            <= 10'(DEF_PULSELEN);
            shWork             <= 8'(DEF_WORK);
            o_parFaimsPeriod   <= 10'(DEF_PERIOD);
            o_parFaimsPulseLen <= 10'(DEF_PULSELEN);
            o_parWork          <= 8'(DEF_WORK);
        end else begin
            if (wrEn) begin
                case (frame.addr)
                    ADDR_CTRL: begin
                        o_enable <= frame.data[CTRL_ENABLE];
                        o_run    <= frame.data[CTRL_RUN];
                        if (frame.data[CTRL_CLRERR]) begin
                            o_err  <= 1'b0;
                            rejCnt <= '0;
                        end
                    end
                    ADDR_PERIOD:   if (!reject) shPeriod <= frame.data[9:0];
                    ADDR_PULSELEN: if (!reject) shPulse  <= frame.data[9:0];
                    ADDR_WORK:     shWork <= frame.data[7:0];
                    default: ;
                endcase
            end
            if (reject) begin
                o_err <= 1'b1;
                if (rejCnt != 8'hFF)
                    rejCnt <= rejCnt + 8'd1;
            end
            // Shadows read here are pre-write values, so a same-cycle write waits for the next strobe.
            if (!o_run || i_periodStrobe) begin
                o_parFaimsPeriod   <= shPeriod;
                o_parFaimsPulseLen <= shPulse;
                o_parWork          <= shWork;
            end
        end
    end

endmodule

// File: tb/tb_faims_spi_regs.sv
// Directed bench for faims_spi_regs: SPI frames driven at CLK/16 with
// hand-computed expectations; readback expectations follow FAIMS_SPI_READBACK_EN.
module tb_faims_spi_regs;

    logic       CLK = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_sclk = 1'b0;
    logic       i_cs_n = 1'b1;
    logic       i_mosi = 1'b0;
    logic       i_periodStrobe = 1'b0;
    logic       o_miso, o_enable, o_run, o_err;
    logic [9:0] o_parFaimsPeriod, o_parFaimsPulseLen;
    logic [7:0] o_parWork;

    int nChecks = 0;
    int nErrors = 0;
    logic [15:0] rdWord;

    faims_spi_regs dut (
        .CLK                (CLK),
        .i_reset            (i_reset),
        .i_sclk             (i_sclk),
        .i_cs_n             (i_cs_n),
        .i_mosi             (i_mosi),
        .o_miso             (o_miso),
        .i_periodStrobe     (i_periodStrobe),
        .o_enable           (o_enable),
        .o_run              (o_run),
        .o_parFaimsPeriod   (o_parFaimsPeriod),
        .o_parFaimsPulseLen (o_parFaimsPulseLen),
        .o_parWork          (o_parWork),
        .o_err              (o_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [23:0] wrFrame(input logic [6:0] a, input logic [15:0] d);
        return {1'b0, a, d};
    endfunction

    function automatic logic [23:0] rdFrame(input logic [6:0] a);
        return {1'b1, a, 16'h0000};
    endfunction

    function automatic logic [15:0] rbExp(input logic [15:0] v);
`ifdef FAIMS_SPI_READBACK_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    // Shift bits first..last-1 of w (index 0 = bit23); MISO sampled before each rising edge.
    task automatic spiBits(input logic [23:0] w, input int first, input int last, output logic [15:0] rd);
        rd = '0;
        for (int i = first; i < last; i++) begin
            i_mosi = w[23-i];
            clks(8);
            if (i >= 8) rd[23-i] = o_miso;
            i_sclk = 1'b1;
            clks(8);
            i_sclk = 1'b0;
        end
        clks(8);
    endtask

    task automatic spiXfer(input logic [23:0] w, input int nbits, output logic [15:0] rd);
        i_cs_n = 1'b0;
        clks(8);
        spiBits(w, 0, nbits, rd);
        i_cs_n = 1'b1;
        clks(8);
    endtask

    task automatic pulseStrobe();
        i_periodStrobe = 1'b1;
        clks(1);
        i_periodStrobe = 1'b0;
    endtask

    initial begin
        clks(2);
        check("rst_period_async", {22'd0, o_parFaimsPeriod}, 32'd250);
        i_reset = 1'b1;
        clks(10);
        check("rst_period", {22'd0, o_parFaimsPeriod}, 32'd250);
        check("rst_pulse", {22'd0, o_parFaimsPulseLen}, 32'd20);
        check("rst_work", {24'd0, o_parWork}, 32'd50);
        check("rst_ctrl", {29'd0, o_enable, o_run, o_err}, 32'd0);
        check("rst_miso", {31'd0, o_miso}, 32'd0);

        // Commit waits for strobe while running
        spiXfer(wrFrame(7'h00, 16'h0003), 24, rdWord);
        check("ctrl_en_run", {30'd0, o_enable, o_run}, 32'd3);
        spiXfer(wrFrame(7'h01, 16'd400), 24, rdWord);
        check("period_no_strobe", {22'd0, o_parFaimsPeriod}, 32'd250);
        pulseStrobe();
        check("period_strobe", {22'd0, o_parFaimsPeriod}, 32'd400);

        // Rejection and clear
        spiXfer(wrFrame(7'h02, 16'd200), 24, rdWord);
        check("pulse200_err", {31'd0, o_err}, 32'd1);
        spiXfer(rdFrame(7'h04), 24, rdWord);
        check("status_0101", {16'd0, rdWord}, {16'd0, rbExp(16'h0101)});
        pulseStrobe();
        check("pulse_kept", {22'd0, o_parFaimsPulseLen}, 32'd20);
        spiXfer(wrFrame(7'h00, 16'h0007), 24, rdWord);
        check("err_cleared", {31'd0, o_err}, 32'd0);
        spiXfer(rdFrame(7'h04), 24, rdWord);
        check("status_0000", {16'd0, rdWord}, 32'd0);

        // Boundaries: 2*199 < 400 ok; period 3 < min; 2*199 >= 398
        spiXfer(wrFrame(7'h02, 16'd199), 24, rdWord);
        check("pulse199_noerr", {31'd0, o_err}, 32'd0);
        check("pulse199_wait", {22'd0, o_parFaimsPulseLen}, 32'd20);
        pulseStrobe();
        check("pulse199_commit", {22'd0, o_parFaimsPulseLen}, 32'd199);
        spiXfer(wrFrame(7'h01, 16'd3), 24, rdWord);
        check("period3_err", {31'd0, o_err}, 32'd1);
        spiXfer(wrFrame(7'h01, 16'd398), 24, rdWord);
        spiXfer(rdFrame(7'h04), 24, rdWord);
        check("status_0201", {16'd0, rdWord}, {16'd0, rbExp(16'h0201)});
        pulseStrobe();
        check("period_kept", {22'd0, o_parFaimsPeriod}, 32'd400);

        // Stop run: outputs then track shadows every cycle
        spiXfer(wrFrame(7'h00, 16'h0004), 24, rdWord);
        check("ctrl_stop", {29'd0, o_enable, o_run, o_err}, 32'd0);

        spiXfer(wrFrame(7'h03, 16'd200), 12, rdWord);
        check("work_partial", {24'd0, o_parWork}, 32'd50);
        spiXfer(wrFrame(7'h03, 16'h00C8), 24, rdWord);
        check("work_full", {24'd0, o_parWork}, 32'd200);
        spiXfer(rdFrame(7'h03), 24, rdWord);
        check("read_work", {16'd0, rdWord}, {16'd0, rbExp(16'h00C8)});
        spiXfer(rdFrame(7'h01), 24, rdWord);
        check("read_period", {16'd0, rdWord}, {16'd0, rbExp(16'h0190)});
        spiXfer(rdFrame(7'h05), 24, rdWord);
        check("read_unmapped", {16'd0, rdWord}, 32'd0);
        spiXfer(wrFrame(7'h03, 16'hFF37), 24, rdWord);
        check("work_hibits", {24'd0, o_parWork}, 32'h37);
        spiXfer(wrFrame(7'h01, 16'd500), 24, rdWord);
        check("period500", {22'd0, o_parFaimsPeriod}, 32'd500);

        // Reset in the middle of a frame
        i_cs_n = 1'b0;
        clks(8);
        spiBits(wrFrame(7'h01, 16'd300), 0, 10, rdWord);
        i_reset = 1'b0;
        #1;
        check("midrst_period", {22'd0, o_parFaimsPeriod}, 32'd250);
        check("midrst_pulse", {22'd0, o_parFaimsPulseLen}, 32'd20);
        check("midrst_work", {24'd0, o_parWork}, 32'd50);
        check("midrst_ctrl", {28'd0, o_enable, o_run, o_err, o_miso}, 32'd0);
        clks(4);
        i_reset = 1'b1;
        clks(4);
        spiBits(wrFrame(7'h01, 16'd300), 10, 24, rdWord);
        i_cs_n = 1'b1;
        clks(8);
        check("midrst_tail_ignored", {22'd0, o_parFaimsPeriod}, 32'd250);
        spiXfer(wrFrame(7'h03, 16'h0011), 24, rdWord);
        check("post_rst_work", {24'd0, o_parWork}, 32'h11);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
